bit_serial_subtractor: RTL and testbench



---
 rtl/bit_serial_subtractor.sv | 120 ++++++++++++
 tb/tb_bit_serial_subtractor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = in1 - in2 - b_in, one bit per clock, LSB first,
// using a single borrow flop behind a start/busy/done handshake.
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             msb1_q, msb1_d;
  logic             msb2_q, msb2_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             bit_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    msb1_d   = msb1_q;
    msb2_d   = msb2_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;
    bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d      = in1;
          b_d      = in2;
          borrow_d = b_in;
          cnt_d    = '0;
          r_d      = '0;
          msb1_d   = in1[WIDTH-1];
          msb2_d   = in2[WIDTH-1];
          state_d  = BUSY;
        end
      end
      BUSY: begin
        borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        r_d      = {bit_d, r_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the result, including the bit computed this edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = r_d;
          b_out_d = borrow_d;
          ovf_d   = (msb1_q != msb2_q) && (bit_d != msb1_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      msb1_q   <= 1'b0;
      msb2_q   <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      msb1_q   <= msb1_d;
      msb2_q   <= msb2_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed and exhaustive checks of bit_serial_subtractor (WIDTH=4): latency,
// handshake, ignored restart, back-to-back start, async reset abort.
module tb_bit_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         b_in = 1'b0;
  logic         busy, done, b_out, ovf;
  logic [W-1:0] diff;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference: integer arithmetic, borrow from unsigned compare.
  task automatic ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                           output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    r  = int'(x) - int'(y) - int'(bi);
    d  = W'(r & 32'hF);
    bo = (int'(x) < int'(y) + int'(bi));
    ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
  endtask

  // Waits (from just after an accepting edge) for done; returns samples taken.
  task automatic wait_done(output int idx, output int busy_n, output bit held);
    logic [W-1:0] prev;
    prev = diff;
    idx = 0; busy_n = 0; held = 1'b1;
    while (!done && idx < 20) begin
      if (busy) busy_n++;
      if (diff !== prev) held = 1'b0;
      @(negedge clk);
      idx++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
    int idx, busy_n;
    bit held;
    @(negedge clk);
    in1 = x; in2 = y; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(idx, busy_n, held);
    check({name, ".latency"}, idx, W);
    check({name, ".busy_cycles"}, busy_n, W);
    check({name, ".held"}, held, 1);
    check({name, ".diff"}, diff, ed);
    check({name, ".b_out"}, b_out, eb);
    check({name, ".ovf"}, ovf, eo);
    $display("op %s: %0d - %0d - %0d -> diff=%0d b_out=%0d ovf=%0d", name, x, y, bi, diff, b_out, ovf);
  endtask

  initial begin
    int idx, busy_n;
    bit held;
    logic [W-1:0] md;
    logic mb, mo;

    vecs[0] = '{a: 4'd4, b: 4'd4,  bi: 1'b0, d: 4'd0,  bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 4'd4, b: 4'd12, bi: 1'b0, d: 4'd8,  bo: 1'b1, ov: 1'b1};
    vecs[2] = '{a: 4'd0, b: 4'd0,  bi: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 4'd7, b: 4'd15, bi: 1'b0, d: 4'd8,  bo: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 4'd9, b: 4'd3,  bi: 1'b1, d: 4'd5,  bo: 1'b0, ov: 1'b1};

    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.diff", diff, 0);
    check("reset.b_out", b_out, 0);
    check("reset.ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].ov);

    // Start pulsed mid-BUSY is ignored; start held in DONE is accepted back-to-back.
    @(negedge clk);
    in1 = 4'd5; in2 = 4'd1; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in1 = 4'd0; in2 = 4'd7; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(idx, busy_n, held);
    check("ignore.latency", idx + 2, W);
    check("ignore.diff", diff, 4'd4);
    check("ignore.b_out", b_out, 0);
    $display("op ignore: 5 - 1 with mid-busy start -> diff=%0d", diff);
    in1 = 4'd9; in2 = 4'd3; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy_now", busy, 1);
    wait_done(idx, busy_n, held);
    check("b2b.latency", idx, W);
    check("b2b.diff", diff, 4'd6);
    check("b2b.b_out", b_out, 0);
    check("b2b.ovf", ovf, 1);
    $display("op b2b: 9 - 3 -> diff=%0d b_out=%0d ovf=%0d", diff, b_out, ovf);

    // Asynchronous reset mid-operation aborts with no done pulse.
    @(negedge clk);
    in1 = 4'd14; in2 = 4'd1; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.diff", diff, 0);
    check("abort.ovf", ovf, 0);
    held = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) held = 1'b1;
    end
    check("abort.no_done", held, 0);
    rst_n = 1'b1;
    $display("op abort: reset during busy");
    do_op("after_reset", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int b = 0; b < 2; b++) begin
          ref_model(W'(x), W'(y), b[0], md, mb, mo);
          do_op("sweep", W'(x), W'(y), b[0], md, mb, mo);
        end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
